// File: rtl/conv_frame_arb_pkg.sv
// Shared FSM encoding and default geometry for the frame arbiter.
// Defaults describe an 8x8 frame feeding a 3x3 valid-only convolution engine.
package conv_frame_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int IMG_W_DEF     = 8;
    localparam int IMG_H_DEF     = 8;
    localparam int DRAIN_MAX_DEF = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a last-served pointer; combinational pick, 0 cycles.
// No backpressure: the pointer moves only when the owner's frame retires (upd).
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic served,
    output logic any,
    output logic win
);

    logic last_q;

    // Reset to "1 served last" so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= served;
        end
    end

    assign any = req0 | req1;
    assign win = (req0 & req1) ? ~last_q : req1;

endmodule

// File: rtl/conv_frame_arb.sv
// Arbitrates one convolution engine between two frame requesters, one whole frame per grant.
// Pixel path 0-cycle combinational; results forwarded with 1-cycle register latency.
// Backpressure: only the granted requester sees pix_rdy; engine results are never stalled.
module conv_frame_arb
    import conv_frame_arb_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    output logic               gnt0,
    output logic               gnt1,
    input  logic               pix_vld0,
    input  logic               pix_vld1,
    input  logic [7:0]         pix0,
    input  logic [7:0]         pix1,
    output logic               pix_rdy0,
    output logic               pix_rdy1,
    output logic               res_vld0,
    output logic               res_vld1,
    output logic signed [31:0] res_out,
    output logic               frame_done0,
    output logic               frame_done1,
    output logic               err,
    output logic               eng_clr,
    output logic               eng_pix_en,
    output logic [7:0]         eng_pixel,
    input  logic signed [31:0] eng_conv_out,
    input  logic               eng_valid
);

    localparam int PIX_N = IMG_W * IMG_H;
    localparam int RES_N = (IMG_W - 2) * (IMG_H - 2);
    localparam int PCW   = $clog2(PIX_N + 1);
    localparam int RCW   = $clog2(RES_N + 1);
    localparam int DCW   = $clog2(DRAIN_MAX + 1);

    state_t             state_q, state_d;
    logic               owner_q;
    logic [PCW-1:0]     pix_cnt_q;
    logic [RCW-1:0]     res_cnt_q, res_cnt_nx;
    logic [DCW-1:0]     drain_cnt_q;
    logic               err_q, res_vld0_q, res_vld1_q;
    logic signed [31:0] res_q;
    logic               arb_any, arb_win;
    logic               xfer, acc, last_pix, res_full, drain_to;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .upd    (state_q == ST_DONE),
        .served (owner_q),
        .any    (arb_any),
        .win    (arb_win)
    );

    always_comb begin
        xfer       = (state_q == ST_STREAM) && (owner_q ? pix_vld1 : pix_vld0);
        acc        = eng_valid && (state_q inside {ST_CLEAR, ST_STREAM, ST_DRAIN});
        // Saturate so surplus engine results can never wrap the count.
        res_cnt_nx = res_cnt_q;
        if (acc && (res_cnt_q != RCW'(RES_N))) begin
            res_cnt_nx = res_cnt_q + RCW'(1);
        end
        last_pix   = xfer && (pix_cnt_q == PCW'(PIX_N - 1));
        res_full   = (res_cnt_nx == RCW'(RES_N));
        drain_to   = (state_q == ST_DRAIN) && !res_full
                     && (drain_cnt_q == DCW'(DRAIN_MAX - 1));

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_any) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_STREAM;
            ST_STREAM: if (last_pix) state_d = ST_DRAIN;
            ST_DRAIN:  if (res_full || drain_to) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            pix_cnt_q   <= '0;
            res_cnt_q   <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            res_vld0_q  <= 1'b0;
            res_vld1_q  <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q    <= state_d;
            res_vld0_q <= acc && !owner_q;
            res_vld1_q <= acc && owner_q;
            if (acc) begin
                res_q <= eng_conv_out;
            end
            if (drain_to) begin
                err_q <= 1'b1;
            end
            // Counters are held at zero while idle, so CLEAR starts from a clean slate.
            if (state_q == ST_IDLE) begin
                pix_cnt_q   <= '0;
                res_cnt_q   <= '0;
                drain_cnt_q <= '0;
                if (arb_any) begin
                    owner_q <= arb_win;
                end
            end else begin
                res_cnt_q <= res_cnt_nx;
                if (xfer) begin
                    pix_cnt_q <= pix_cnt_q + PCW'(1);
                end
                if (state_q == ST_DRAIN) begin
                    drain_cnt_q <= drain_cnt_q + DCW'(1);
                end
            end
        end
    end

    assign gnt0        = (state_q != ST_IDLE) && !owner_q;
    assign gnt1        = (state_q != ST_IDLE) && owner_q;
    assign pix_rdy0    = (state_q == ST_STREAM) && !owner_q;
    assign pix_rdy1    = (state_q == ST_STREAM) && owner_q;
    assign frame_done0 = (state_q == ST_DONE) && !owner_q;
    assign frame_done1 = (state_q == ST_DONE) && owner_q;
    assign eng_clr     = (state_q == ST_CLEAR);
    assign eng_pix_en  = xfer;
    assign eng_pixel   = xfer ? (owner_q ? pix1 : pix0) : 8'd0;
    assign res_vld0    = res_vld0_q;
    assign res_vld1    = res_vld1_q;
    assign res_out     = res_q;
    assign err         = err_q;

endmodule

// File: tb/tb_conv_frame_arb.sv
// Randomized bench for conv_frame_arb against a frame-level reference model and engine stub.
module tb_conv_frame_arb;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int DMAX = 64;
    localparam int PIXN = W * H;
    localparam int RESN = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst;
    logic req0, req1, gnt0, gnt1;
    logic pix_vld0, pix_vld1, pix_rdy0, pix_rdy1;
    logic [7:0] pix0, pix1, eng_pixel;
    logic res_vld0, res_vld1, frame_done0, frame_done1, err;
    logic eng_clr, eng_pix_en, eng_valid;
    logic signed [31:0] res_out, eng_conv_out;

    always #5 clk = ~clk;

    conv_frame_arb #(.IMG_W(W), .IMG_H(H), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .pix_vld0(pix_vld0), .pix_vld1(pix_vld1), .pix0(pix0), .pix1(pix1),
        .pix_rdy0(pix_rdy0), .pix_rdy1(pix_rdy1), .res_vld0(res_vld0), .res_vld1(res_vld1),
        .res_out(res_out), .frame_done0(frame_done0), .frame_done1(frame_done1), .err(err),
        .eng_clr(eng_clr), .eng_pix_en(eng_pix_en), .eng_pixel(eng_pixel),
        .eng_conv_out(eng_conv_out), .eng_valid(eng_valid)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus knobs
    int quota0 = 0, quota1 = 0, vld_pct0 = 100, vld_pct1 = 100, res_limit = RESN;
    bit sp_en = 0;
    int rst_at_pix = -1;
    bit rst_drv = 0, rst_prev = 0;

    // Reference model state
    int cur = -1;
    bit gnt_prev = 0, fd_prev = 0, rq0_prev = 0, rq1_prev = 0;
    bit last_m = 1'b1, err_m = 1'b0, rdy_m = 1'b0;
    int xfers = 0, res_seen = 0, emitted = 0, eng_k = 0;
    bit pend = 0;
    logic signed [31:0] pend_dat, slot_dat;
    bit slot = 0;
    int slot_who = 0;
    int cyc = 0, last_xfer_cyc = 0, nframes = 0;
    logic [7:0] hist = '0;

    task automatic step();
        bit gnt_any, fd_any, rise, exp_own, xfer_e;
        logic [1:0] res_exp;
        @(negedge clk);
        cyc++;
        // Outputs that depend on state only
        if (rst_prev) begin
            chk("rst_zero", {gnt0, gnt1, pix_rdy0, pix_rdy1, res_vld0, res_vld1, frame_done0,
                             frame_done1, eng_clr, eng_pix_en, eng_pixel, err, res_out}, 64'd0);
            cur = -1; gnt_prev = 0; fd_prev = 0; last_m = 1'b1; err_m = 1'b0;
            slot = 0; pend = 0;
        end
        gnt_any = gnt0 | gnt1;
        fd_any  = frame_done0 | frame_done1;
        res_exp = slot ? ((slot_who == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("res_vld", {res_vld1, res_vld0}, res_exp);
        if (slot) chk("res_out", res_out, slot_dat);
        if (cur >= 0 && ((cur == 1) ? res_vld1 : res_vld0)) res_seen++;
        chk("no_leak", {(pix_rdy0 | res_vld0 | frame_done0) & ~gnt0,
                        (pix_rdy1 | res_vld1 | frame_done1) & ~gnt1, gnt0 & gnt1}, 3'b000);
        if (fd_prev) chk("gnt_drop", gnt_any, 1'b0);
        rise = gnt_any && !gnt_prev;
        chk("eng_clr", eng_clr, rise);
        if (rise) begin
            if (rq0_prev && rq1_prev) exp_own = !last_m;
            else                      exp_own = rq1_prev;
            chk("gnt_owner", {gnt1, gnt0}, exp_own ? 2'b10 : 2'b01);
            cur = exp_own ? 1 : 0;
            xfers = 0; res_seen = 0;
            if (cur == 1) quota1--; else quota0--;
            hist = {hist[6:0], exp_own};
        end
        if (eng_clr) begin eng_k = 0; emitted = 0; end
        rdy_m = (cur >= 0) && !rise && (xfers < PIXN);
        if (cur >= 0) chk("pix_rdy", (cur == 1) ? pix_rdy1 : pix_rdy0, rdy_m);
        if (fd_any) begin
            chk("fd_owner", {frame_done1, frame_done0}, (cur == 1) ? 2'b10 : 2'b01);
            chk("fd_xfers", xfers, PIXN);
            chk("fd_results", res_seen, emitted);
            if (emitted < RESN) begin
                err_m = 1'b1;
                chk("drain_timeout", cyc - last_xfer_cyc, DMAX + 1);
            end
            chk("fd_err", err, err_m);
            last_m = (cur == 1);
            nframes++;
        end
        fd_prev  = fd_any;
        gnt_prev = gnt_any;
        if (!gnt_any) cur = -1;

        // Drive inputs
        rst      = rst_drv;
        rst_prev = rst_drv;
        rst_drv  = 0;
        req0 = (quota0 > 0); req1 = (quota1 > 0);
        rq0_prev = req0; rq1_prev = req1;
        pix_vld0 = ($urandom_range(99) < vld_pct0); pix0 = 8'($urandom);
        pix_vld1 = ($urandom_range(99) < vld_pct1); pix1 = 8'($urandom);
        slot = 0;
        if (pend) begin
            eng_valid = 1'b1; eng_conv_out = pend_dat;
            slot = gnt_any && !fd_any; slot_dat = pend_dat; slot_who = cur;
            pend = 0;
        end else if (sp_en && (!gnt_any || fd_any) && $urandom_range(2) == 0) begin
            eng_valid = 1'b1; eng_conv_out = $urandom;
        end else begin
            eng_valid = 1'b0; eng_conv_out = $urandom;
        end

        // Pixel path and engine stub
        #1;
        xfer_e = rdy_m && ((cur == 1) ? pix_vld1 : pix_vld0);
        chk("eng_pix_en", eng_pix_en, xfer_e);
        chk("eng_pixel", eng_pixel, xfer_e ? ((cur == 1) ? pix1 : pix0) : 8'd0);
        if (xfer_e) begin
            xfers++;
            last_xfer_cyc = cyc;
            if ((eng_k / W) >= 2 && (eng_k % W) >= 2 && emitted < res_limit) begin
                pend = 1; pend_dat = $urandom; emitted++;
            end
            eng_k++;
            if (rst_at_pix > 0 && xfers == rst_at_pix) begin
                rst_drv = 1; rst_at_pix = -1;
            end
        end
    endtask

    task automatic run(input int maxc, input string tag);
        int n;
        bit idle;
        n = 0;
        idle = 0;
        while (!idle && n < maxc) begin
            step();
            n++;
            idle = (quota0 <= 0) && (quota1 <= 0) && (cur < 0) && !gnt_prev
                   && !rst_drv && !rst_prev;
        end
        chk({tag, "_complete"}, idle, 1'b1);
    endtask

    task automatic do_reset();
        rst_drv = 1;
        step();
        step();
    endtask

    int saved;

    initial begin
        rst = 1; req0 = 0; req1 = 0; pix_vld0 = 0; pix_vld1 = 0; pix0 = 0; pix1 = 0;
        eng_valid = 0; eng_conv_out = 0;
        repeat (2) @(posedge clk);
        rst_prev = 1;

        // Single requester, full rate
        quota0 = 1;
        run(600, "single");

        // Simultaneous requests after reset, then alternation
        do_reset();
        hist = '0;
        quota0 = 2; quota1 = 1;
        run(2000, "rr");
        chk("rr_order", hist[2:0], 3'b010);

        // Gappy pixel valid
        vld_pct0 = 50;
        quota0 = 1;
        run(1200, "gappy");
        vld_pct0 = 100;

        // Engine one result short -> drain timeout
        res_limit = RESN - 1;
        quota0 = 1;
        run(800, "timeout");
        res_limit = RESN;

        // Spurious engine pulses around frames; err stays sticky
        sp_en = 1;
        repeat (10) step();
        quota1 = 1;
        run(800, "spur1");
        quota0 = 1;
        run(800, "spur0");
        sp_en = 0;

        // Reset mid-frame, then a clean frame for requester 1
        saved = nframes;
        quota0 = 1;
        rst_at_pix = 30;
        run(600, "abort");
        chk("no_fd_on_abort", nframes, saved);
        quota1 = 1;
        run(600, "after_abort");
        chk("after_abort_frames", nframes, saved + 1);

        // Random mix
        for (int i = 0; i < 6; i++) begin
            quota0 = $urandom_range(2);
            quota1 = $urandom_range(2);
            vld_pct0 = 30 + $urandom_range(70);
            vld_pct1 = 30 + $urandom_range(70);
            sp_en = $urandom_range(1);
            run(5000, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_frame_arb.md
CONV_FRAME_ARB -- requirements
Module: conv_frame_arb

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (>=3).
REQ-002 Parameter IMG_H, default 8, image height in pixels (>=3).
REQ-003 Parameter DRAIN_MAX, default 64, max cycles to wait for remaining results after the last pixel.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req0 / req1  input  1  requester n wants to convolve one frame.
REQ-008 gnt0 / gnt1  output  1  requester n owns the engine for the current frame.
REQ-009 pix_vld0 / pix_vld1  input  1  requester n presents a pixel.
REQ-010 pix0 / pix1  input  8  requester n pixel, row-major.
REQ-011 pix_rdy0 / pix_rdy1  output  1  arbiter accepts requester n pixel this cycle.
REQ-012 res_vld0 / res_vld1  output  1  result for requester n valid.
REQ-013 res_out  output  32 signed  result data, shared by both requesters.
REQ-014 frame_done0 / frame_done1  output  1  one-cycle pulse at end of requester n frame.
REQ-015 err  output  1  sticky: drain timeout occurred.
REQ-016 eng_clr  output  1  one-cycle clear of engine line buffers.
REQ-017 eng_pix_en  output  1  eng_pixel is a valid engine input.
REQ-018 eng_pixel  output  8  pixel to engine.
REQ-019 eng_conv_out  input  32 signed  engine result.
REQ-020 eng_valid  input  1  engine result valid.

Function
REQ-021 States: IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-022 IDLE: if any req, grant per round-robin, go to CLEAR; gnt asserted from the CLEAR cycle until DONE inclusive.
REQ-023 Round-robin: with both req high, the requester not served last wins; after reset requester 0 has priority.
REQ-024 CLEAR: eng_clr=1 for exactly one cycle, pixel and result counters zeroed, then STREAM.
REQ-025 STREAM: pix_rdy of granted requester=1, other=0; a pixel transfers when pix_vld&pix_rdy; same cycle eng_pix_en=1, eng_pixel=pixel (combinational path, 0 latency).
REQ-026 eng_pix_en=0 and eng_pixel=0 in every cycle with no transfer.
REQ-027 After IMG_W*IMG_H transfers (64 default) pix_rdy drops next cycle and the FSM goes to DRAIN.
REQ-028 Results: in CLEAR, STREAM and DRAIN each eng_valid is forwarded registered (1-cycle latency) on res_out with res_vld of the granted requester; results are counted.
REQ-029 DRAIN: when the result count reaches (IMG_W-2)*(IMG_H-2) (36 default) go to DONE; if DRAIN_MAX cycles elapse first, set err and go to DONE.
REQ-030 Results arriving in STREAM also count; reaching 36 before the pixel count is complete does not end the frame early.
REQ-031 eng_valid outside CLEAR/STREAM/DRAIN is ignored (no res_vld, not counted).
REQ-032 DONE: frame_done of granted requester pulses 1 cycle, last-served pointer updated, return to IDLE; gnt drops the following cycle.
REQ-033 req deassertion after grant is ignored; the frame runs to completion.
REQ-034 Counters sized by $clog2 of their maximum; no wrap within a frame.
REQ-035 Only the granted requester ever sees pix_rdy, res_vld or frame_done high.

Reset
REQ-036 On rst: state IDLE, all gnt/pix_rdy/res_vld/frame_done/eng_clr/eng_pix_en=0, eng_pixel=0, res_out=0, err=0, counters=0, priority to requester 0.
REQ-037 rst mid-frame aborts immediately; no frame_done pulse is issued; err is cleared only by rst.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding and the default IMG_W/IMG_H/DRAIN_MAX constants.
REQ-039 One sub-module, rr_arb2 (2-way round-robin with last-served pointer), SHALL be instantiated; the remainder is flat.

Verification
REQ-040 Single req0 and 64 pixels at full rate, engine model emits 36 results -> gnt0, 64 eng_pix_en, 36 res_vld0, one frame_done0, err=0.
REQ-041 req0 and req1 asserted together after reset -> requester 0 served first, then requester 1; with both held high, grants alternate 0,1,0.
REQ-042 pix_vld0 toggled 1-0-1 -> eng_pix_en mirrors each transfer only; frame still completes after exactly 64 transfers.
REQ-043 Engine model emits only 35 results -> after DRAIN_MAX=64 cycles err=1, frame_done0 pulses, FSM returns to IDLE.
REQ-044 rst asserted at pixel 30 -> next cycle all outputs at reset values, no frame_done; new req1 then runs a full clean frame.
REQ-045 eng_valid pulsed in IDLE and during the other requester's frame -> never forwarded to the non-granted requester; result count unaffected.
